// File: rtl/pll_reconfig_seq.sv
// Drives the PLL reconfiguration port (mode, fractional word, start) whenever the synchronised underclock level differs from the applied one.
// Optional lock wait with sticky timeout under `PLL_RECONFIG_LOCK_WAIT_EN`; writes are held until accepted, with no handshake timeout.
module pll_reconfig_seq #(
  parameter logic [31:0] FRAC_NATIVE  = 32'hD8EC95C0,
  parameter logic [31:0] FRAC_UNDER   = 32'hC2CE464A,
  parameter int unsigned LOCK_TIMEOUT = 500000
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic        underclock,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, MODE, FRAC, START, WAIT_BUSY, WAIT_LOCK, DONE
  } state_t;

  state_t      state, state_nxt;
  logic        s1, s2, s3;
  logic        applied, applied_nxt;
  logic        write_nxt;
  logic [5:0]  addr_nxt;
  logic [31:0] data_nxt;
  logic        req;

  // s2==s3 rejects a level that is still moving through the synchroniser
  assign req  = (s2 == s3) && (s3 != applied);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

`ifdef PLL_RECONFIG_LOCK_WAIT_EN
  localparam int CW = ($clog2(LOCK_TIMEOUT + 1) > 20) ? $clog2(LOCK_TIMEOUT + 1) : 20;
  localparam logic [CW-1:0] LT    = CW'(LOCK_TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'((LOCK_TIMEOUT == 0) ? 0 : LOCK_TIMEOUT - 1);

  logic          lock1, lock2;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          terr, terr_nxt;

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      lock1 <= 1'b0;
      lock2 <= 1'b0;
      cnt   <= '0;
      terr  <= 1'b0;
    end else begin
      lock1 <= pll_locked;
      lock2 <= lock1;
      cnt   <= cnt_nxt;
      terr  <= terr_nxt;
    end
  end

  assign timeout_err = terr;
`else
  logic unused_lock;
  assign unused_lock = pll_locked ^ (LOCK_TIMEOUT == 0);
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      s1             <= 1'b0;
      s2             <= 1'b0;
      s3             <= 1'b0;
      applied        <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
    end else begin
      state          <= state_nxt;
      s1             <= underclock;
      s2             <= s1;
      s3             <= s2;
      applied        <= applied_nxt;
      mgmt_write     <= write_nxt;
      mgmt_address   <= addr_nxt;
      mgmt_writedata <= data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    applied_nxt = applied;
    write_nxt   = mgmt_write;
    addr_nxt    = mgmt_address;
    data_nxt    = mgmt_writedata;
`ifdef PLL_RECONFIG_LOCK_WAIT_EN
    cnt_nxt     = cnt;
    terr_nxt    = terr;
`endif
    case (state)
      IDLE: begin
        if (req) begin
          applied_nxt = s3;
          state_nxt   = MODE;
          write_nxt   = 1'b1;
          addr_nxt    = 6'd0;
          data_nxt    = 32'd0;
`ifdef PLL_RECONFIG_LOCK_WAIT_EN
          terr_nxt    = 1'b0;
`endif
        end
      end
      MODE: begin
        if (mgmt_write && !mgmt_waitrequest) begin
          write_nxt = 1'b0;
          state_nxt = FRAC;
        end
      end
      // Entering with the strobe low gives the one-clock gap between writes
      FRAC: begin
        if (!mgmt_write) begin
          write_nxt = 1'b1;
          addr_nxt  = 6'd7;
          data_nxt  = applied ? FRAC_UNDER : FRAC_NATIVE;
        end else if (!mgmt_waitrequest) begin
          write_nxt = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (!mgmt_write) begin
          write_nxt = 1'b1;
          addr_nxt  = 6'd2;
          data_nxt  = 32'd0;
        end else if (!mgmt_waitrequest) begin
          write_nxt = 1'b0;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!mgmt_waitrequest) begin
`ifdef PLL_RECONFIG_LOCK_WAIT_EN
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef PLL_RECONFIG_LOCK_WAIT_EN
      WAIT_LOCK: begin
        if (lock2) begin
          state_nxt = DONE;
        end else if (cnt >= LIMIT) begin
          terr_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = (cnt == LT) ? cnt : cnt + CW'(1);
        end
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_pll_reconfig_seq;

  localparam logic [31:0] NAT = 32'hD8EC95C0;
  localparam logic [31:0] UND = 32'hC2CE464A;
`ifdef PLL_RECONFIG_LOCK_WAIT_EN
  localparam int   EXP_LAT  = 101;
  localparam int   LAT_TOL  = 3;
  localparam logic EXP_TERR = 1'b1;
`else
  localparam int   EXP_LAT  = 1;
  localparam int   LAT_TOL  = 0;
  localparam logic EXP_TERR = 1'b0;
`endif

  logic        clk_50m = 1'b0;
  logic        reset = 1'b0;
  logic        underclock = 1'b0;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b0;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int n_chk = 0;
  int n_fail = 0;

  always #10 clk_50m = ~clk_50m;

  pll_reconfig_seq #(.LOCK_TIMEOUT(100)) dut (
    .clk_50m(clk_50m),
    .reset(reset),
    .underclock(underclock),
    .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked(pll_locked),
    .mgmt_write(mgmt_write),
    .mgmt_address(mgmt_address),
    .mgmt_writedata(mgmt_writedata),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err)
  );

  // accepted writes and done pulses
  logic [5:0]  acc_addr[$];
  logic [31:0] acc_data[$];
  int          done_cnt = 0;

  always @(negedge clk_50m) begin
    if (reset) begin
      if (mgmt_write && !mgmt_waitrequest) begin
        acc_addr.push_back(mgmt_address);
        acc_data.push_back(mgmt_writedata);
      end
      if (done) done_cnt++;
    end
  end

  typedef struct {
    logic        uc;
    logic        wr;
    logic        lk;
    logic        e_wr;
    logic [5:0]  e_addr;
    logic [31:0] e_data;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic uc, input logic wr, input logic lk, input logic e_wr,
                     input logic [5:0] e_addr, input logic [31:0] e_data,
                     input logic e_busy, input logic e_done);
    vec_t v;
    v.uc = uc; v.wr = wr; v.lk = lk; v.e_wr = e_wr;
    v.e_addr = e_addr; v.e_data = e_data; v.e_busy = e_busy; v.e_done = e_done;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return busy;
      1:       return done;
      2:       return mgmt_write && (mgmt_address == 6'd2);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input string name, input int sel, input int budget, output int n);
    n = 0;
    while (!cond(sel) && n < budget) begin
      step();
      n++;
    end
    if (!cond(sel)) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: condition not seen within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    int base;
    int dbase;
    int busy_seen;

    // first sequence: 0->1, no stalls
    add(0,0,1, 0,6'd0,32'd0, 0,0);
    add(1,0,1, 0,6'd0,32'd0, 0,0);
    add(1,0,1, 0,6'd0,32'd0, 0,0);
    add(1,0,1, 0,6'd0,32'd0, 0,0);
    add(1,0,1, 1,6'd0,32'd0, 1,0);
    add(1,0,1, 0,6'd0,32'd0, 1,0);
    add(1,0,1, 1,6'd7,UND,   1,0);
    add(1,0,1, 0,6'd7,UND,   1,0);
    add(1,0,1, 1,6'd2,32'd0, 1,0);
    add(1,0,1, 0,6'd2,32'd0, 1,0);
`ifdef PLL_RECONFIG_LOCK_WAIT_EN
    add(1,0,1, 0,6'd2,32'd0, 1,0);
`endif
    add(1,0,1, 0,6'd2,32'd0, 1,1);
    add(1,0,1, 0,6'd2,32'd0, 0,0);
    add(1,0,1, 0,6'd2,32'd0, 0,0);
    // second sequence: 1->0, FRAC write stalled five clocks, WAIT_BUSY stalled one
    add(0,0,1, 0,6'd2,32'd0, 0,0);
    add(0,0,1, 0,6'd2,32'd0, 0,0);
    add(0,0,1, 0,6'd2,32'd0, 0,0);
    add(0,0,1, 1,6'd0,32'd0, 1,0);
    add(0,0,1, 0,6'd0,32'd0, 1,0);
    add(0,0,1, 1,6'd7,NAT,   1,0);
    for (int k = 0; k < 5; k++) add(0,1,1, 1,6'd7,NAT, 1,0);
    add(0,0,1, 0,6'd7,NAT,   1,0);
    add(0,0,1, 1,6'd2,32'd0, 1,0);
    add(0,0,1, 0,6'd2,32'd0, 1,0);
    add(0,1,1, 0,6'd2,32'd0, 1,0);
`ifdef PLL_RECONFIG_LOCK_WAIT_EN
    add(0,0,1, 0,6'd2,32'd0, 1,0);
`endif
    add(0,0,1, 0,6'd2,32'd0, 1,1);
    add(0,0,1, 0,6'd2,32'd0, 0,0);

    // reset state
    underclock = 1'b1;
    pll_locked = 1'b1;
    step();
    step();
    check("rst write", 32'(mgmt_write), 32'd0);
    check("rst addr", 32'(mgmt_address), 32'd0);
    check("rst data", mgmt_writedata, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst terr", 32'(timeout_err), 32'd0);
    underclock = 1'b0;
    reset = 1'b1;

    foreach (vecs[i]) begin
      underclock       = vecs[i].uc;
      mgmt_waitrequest = vecs[i].wr;
      pll_locked       = vecs[i].lk;
      step();
      check($sformatf("vec%0d write", i), 32'(mgmt_write), 32'(vecs[i].e_wr));
      check($sformatf("vec%0d addr", i), 32'(mgmt_address), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d data", i), mgmt_writedata, vecs[i].e_data);
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d terr", i), 32'(timeout_err), 32'd0);
    end

    // 0->1, then a persisting 1->0 while busy: second sequence right after done
    base = acc_addr.size();
    dbase = done_cnt;
    mgmt_waitrequest = 1'b0;
    underclock = 1'b1;
    wait_cond("B busy", 0, 20, n);
    underclock = 1'b0;
    wait_cond("B done1", 1, 300, n);
    step();
    check("B idle after done", 32'(busy), 32'd0);
    step();
    check("B restart busy", 32'(busy), 32'd1);
    check("B restart write", 32'(mgmt_write), 32'd1);
    wait_cond("B done2", 1, 300, n);
    step();
    check("B write count", 32'(acc_addr.size() - base), 32'd6);
    check("B frac1 data", acc_data[base+1], UND);
    check("B frac2 addr", 32'(acc_addr[base+4]), 32'd7);
    check("B frac2 data", acc_data[base+4], NAT);
    check("B done count", 32'(done_cnt - dbase), 32'd2);

    // 0->1, then a 1->0->1 glitch while busy: no second sequence
    base = acc_addr.size();
    dbase = done_cnt;
    underclock = 1'b1;
    wait_cond("A busy", 0, 20, n);
    underclock = 1'b0;
    step();
    step();
    underclock = 1'b1;
    wait_cond("A done", 1, 300, n);
    step();
    busy_seen = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (busy) busy_seen++;
    end
    check("A no second seq", 32'(busy_seen), 32'd0);
    check("A write count", 32'(acc_addr.size() - base), 32'd3);
    check("A done count", 32'(done_cnt - dbase), 32'd1);

    // lock never asserts: timeout path or direct completion
    pll_locked = 1'b0;
    underclock = 1'b0;
    wait_cond("C start write", 2, 50, n);
    step();
    check("C start accepted", 32'(mgmt_write), 32'd0);
    wait_cond("C done", 1, 300, lat);
    check("C done latency", 32'((lat >= EXP_LAT - LAT_TOL) && (lat <= EXP_LAT + LAT_TOL)), 32'd1);
    check("C terr at done", 32'(timeout_err), 32'(EXP_TERR));
    step();
    check("C done one clock", 32'(done), 32'd0);
    check("C terr sticky", 32'(timeout_err), 32'(EXP_TERR));
    pll_locked = 1'b1;
    underclock = 1'b1;
    wait_cond("C2 busy", 0, 20, n);
    check("C2 terr cleared", 32'(timeout_err), 32'd0);
    wait_cond("C2 done", 1, 300, n);
    check("C2 terr at done", 32'(timeout_err), 32'd0);
    step();

    // reset while the START write is stalled, then a fresh sequence
    underclock = 1'b0;
    wait_cond("D start write", 2, 50, n);
    mgmt_waitrequest = 1'b1;
    step();
    check("D start held", 32'(mgmt_write), 32'd1);
    reset = 1'b0;
    #1;
    check("D rst write", 32'(mgmt_write), 32'd0);
    check("D rst addr", 32'(mgmt_address), 32'd0);
    check("D rst data", mgmt_writedata, 32'd0);
    check("D rst busy", 32'(busy), 32'd0);
    check("D rst done", 32'(done), 32'd0);
    check("D rst terr", 32'(timeout_err), 32'd0);
    base = acc_addr.size();
    dbase = done_cnt;
    step();
    step();
    step();
    mgmt_waitrequest = 1'b0;
    underclock = 1'b1;
    reset = 1'b1;
    wait_cond("D busy", 0, 20, n);
    wait_cond("D done", 1, 300, n);
    step();
    check("D write count", 32'(acc_addr.size() - base), 32'd3);
    check("D w0 addr", 32'(acc_addr[base]), 32'd0);
    check("D w1 addr", 32'(acc_addr[base+1]), 32'd7);
    check("D w1 data", acc_data[base+1], UND);
    check("D w2 addr", 32'(acc_addr[base+2]), 32'd2);
    check("D done count", 32'(done_cnt - dbase), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
